wishbone_timer_slave: RTL

//  Memory-mapped 32-bit timer: Wishbone slave on a free interconnect master port (slave 3).

---
 rtl/wishbone_timer_slave.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/wishbone_timer_slave.sv
`default_nettype none
// ============================================================================
//  Module   : wishbone_timer_slave
//  Purpose  : Memory-mapped 32-bit timer on a Wishbone slave port. It has a
//             prescaled up-counter with compare match, auto-reload and
//             one-shot modes, write-1-to-clear status flags and a registered
//             level interrupt.
//  Ports    : i_CLK/i_RST    clock, asynchronous active-high reset
//             i_ADDR/i_DATA  byte address (word offset i_ADDR[4:2]), wdata
//             o_DATA         read data, valid while o_ACK=1
//             i_WE/i_SEL     write enable, byte enables
//             i_STB/i_CYC    strobe / bus cycle valid
//             o_ACK          single-cycle acknowledge
//             i_TAGN/o_TAGN  request tag, returned with o_ACK
//             o_IRQ          CTRL.IE & STATUS.MATCH, registered
//             o_PWM          PWM output (only with TIMER_PWM_EN)
//  Options  : TIMER_PWM_EN   adds o_PWM and the DUTY register at 0x14
//  Revision : 1.0  initial release
// ============================================================================
module wishbone_timer_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int PRESC_WIDTH = 16
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic [ADDR_WIDTH-1:0] i_ADDR,
    input  logic [DATA_WIDTH-1:0] i_DATA,
    output logic [DATA_WIDTH-1:0] o_DATA,
    input  logic                  i_WE,
    input  logic [3:0]            i_SEL,
    input  logic                  i_STB,
    output logic                  o_ACK,
    input  logic                  i_CYC,
    input  logic                  i_TAGN,
    output logic                  o_TAGN,
`ifdef TIMER_PWM_EN
    output logic                  o_PWM,
`endif
    output logic                  o_IRQ
);

    localparam logic [2:0] c_OFF_CTRL    = 3'd0;
    localparam logic [2:0] c_OFF_PRESC   = 3'd1;
    localparam logic [2:0] c_OFF_COUNT   = 3'd2;
    localparam logic [2:0] c_OFF_COMPARE = 3'd3;
    localparam logic [2:0] c_OFF_STATUS  = 3'd4;
`ifdef TIMER_PWM_EN
    localparam logic [2:0] c_OFF_DUTY    = 3'd5;
`endif

    // Replace the byte lanes selected by sel with the new value.
    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    logic [3:0]             r_ctrl;      // {ONESHOT, RELOAD, IE, EN}
    logic [PRESC_WIDTH-1:0] r_presc;
    logic [PRESC_WIDTH-1:0] r_presc_cnt;
    logic [31:0]            r_count;
    logic [31:0]            r_compare;
    logic                   r_match;
    logic                   r_ovf;
`ifdef TIMER_PWM_EN
    logic [31:0]            r_duty;
`endif

    logic        w_en;
    logic        w_ie;
    logic        w_reload;
    logic        w_oneshot;
    logic        w_accept;
    logic        w_wr;
    logic [2:0]  w_off;
    logic        w_wr_ctrl;
    logic        w_wr_presc;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_tick;
    logic        w_match;
    logic        w_wrap;
    logic        w_clr_match;
    logic        w_clr_ovf;
    logic [31:0] w_ctrl_merged;
    logic [31:0] w_presc_merged;
    logic [31:0] w_count_merged;
    logic [31:0] w_compare_merged;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_en      = r_ctrl[0];
    assign w_ie      = r_ctrl[1];
    assign w_reload  = r_ctrl[2];
    assign w_oneshot = r_ctrl[3];

    // A held strobe is accepted only while no acknowledge is outstanding,
    // so back-to-back requests are taken every second cycle.
    assign w_accept     = i_CYC & i_STB & ~o_ACK;
    assign w_wr         = w_accept & i_WE;
    assign w_off        = i_ADDR[4:2];
    assign w_wr_ctrl    = w_wr & (w_off == c_OFF_CTRL);
    assign w_wr_presc   = w_wr & (w_off == c_OFF_PRESC);
    assign w_wr_count   = w_wr & (w_off == c_OFF_COUNT);
    assign w_wr_compare = w_wr & (w_off == c_OFF_COMPARE);
    assign w_wr_status  = w_wr & (w_off == c_OFF_STATUS);

    assign w_tick  = w_en & (r_presc_cnt == r_presc);
    assign w_match = w_tick & (r_count == r_compare);
    // Overflow only when the counter actually increments past all-ones;
    // a reload to zero is not an overflow.
    assign w_wrap  = w_tick & ~(w_match & w_reload) & (r_count == 32'hFFFF_FFFF);

    assign w_clr_match = w_wr_status & i_SEL[0] & i_DATA[0];
    assign w_clr_ovf   = w_wr_status & i_SEL[0] & i_DATA[1];

    assign w_ctrl_merged    = f_merge({28'd0, r_ctrl}, i_DATA, i_SEL);
    assign w_presc_merged   = f_merge(32'(r_presc), i_DATA, i_SEL);
    assign w_count_merged   = f_merge(r_count, i_DATA, i_SEL);
    assign w_compare_merged = f_merge(r_compare, i_DATA, i_SEL);

    // Register bits that are never stored.
    assign w_unused = ^{i_ADDR[ADDR_WIDTH-1:5], i_ADDR[1:0],
                        w_ctrl_merged[31:4], w_presc_merged[31:PRESC_WIDTH]};

    always_comb begin
        w_rdata = '0;
        case (w_off)
            c_OFF_CTRL:    w_rdata = {28'd0, r_ctrl};
            c_OFF_PRESC:   w_rdata = 32'(r_presc);
            c_OFF_COUNT:   w_rdata = r_count;
            c_OFF_COMPARE: w_rdata = r_compare;
            c_OFF_STATUS:  w_rdata = {30'd0, r_ovf, r_match};
`ifdef TIMER_PWM_EN
            c_OFF_DUTY:    w_rdata = r_duty;
`endif
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_ACK       <= 1'b0;
            o_DATA      <= '0;
            o_TAGN      <= 1'b0;
            o_IRQ       <= 1'b0;
            r_ctrl      <= '0;
            r_presc     <= '0;
            r_presc_cnt <= '0;
            r_count     <= '0;
            r_compare   <= 32'hFFFF_FFFF;
            r_match     <= 1'b0;
            r_ovf       <= 1'b0;
`ifdef TIMER_PWM_EN
            r_duty      <= '0;
            o_PWM       <= 1'b0;
`endif
        end else begin
            // Bus response
            o_ACK  <= w_accept;
            o_DATA <= w_accept ? w_rdata : '0;
            if (w_accept) begin
                o_TAGN <= i_TAGN;
            end

            // Control; a one-shot match disabling the timer overrides a
            // same-cycle software write of EN=1.
            if (w_wr_ctrl) begin
                r_ctrl <= w_ctrl_merged[3:0];
            end
            if (w_match & w_oneshot) begin
                r_ctrl[0] <= 1'b0;
            end

            if (w_wr_presc) begin
                r_presc <= w_presc_merged[PRESC_WIDTH-1:0];
            end

            // Prescaler restarts on any reconfiguration of CTRL or PRESC.
            if (w_wr_ctrl | w_wr_presc) begin
                r_presc_cnt <= '0;
            end else if (w_tick) begin
                r_presc_cnt <= '0;
            end else if (w_en) begin
                r_presc_cnt <= r_presc_cnt + PRESC_WIDTH'(1);
            end

            // Software writes to COUNT take priority over the tick update.
            if (w_wr_count) begin
                r_count <= w_count_merged;
            end else if (w_tick) begin
                r_count <= (w_match & w_reload) ? 32'd0 : r_count + 32'd1;
            end

            if (w_wr_compare) begin
                r_compare <= w_compare_merged;
            end

            // Hardware set wins over a same-cycle write-1-to-clear.
            r_match <= (r_match & ~w_clr_match) | w_match;
            r_ovf   <= (r_ovf & ~w_clr_ovf) | w_wrap;

            o_IRQ <= w_ie & r_match;

`ifdef TIMER_PWM_EN
            if (w_wr & (w_off == c_OFF_DUTY)) begin
                r_duty <= f_merge(r_duty, i_DATA, i_SEL);
            end
            o_PWM <= w_en & (r_count < r_duty);
`endif
        end
    end

endmodule
`default_nettype wire
